// File: rtl/ysyx_22040088_defines.sv
// Shared definitions for the EXU multiply/divide unit: data width, divider
// FSM encoding, MDU op bit positions inside alu_op, and small helpers.
package ysyx_22040088_defines;

    localparam int XLEN  = 64;
    localparam int WLEN  = XLEN / 2;
    localparam int CNT_W = $clog2(XLEN) + 1;

    // Divider FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // One-hot MDU op bit indices inside alu_op[16:11]
    localparam int MDU_OP_MUL  = 11;
    localparam int MDU_OP_DIV  = 12;
    localparam int MDU_OP_DIVU = 13;
    localparam int MDU_OP_REM  = 14;
    localparam int MDU_OP_REMU = 15;
    localparam int MDU_OP_WORD = 16;

    // Sign-extend a word-mode value to the full register width.
    function automatic logic [XLEN-1:0] sext_word(input logic [WLEN-1:0] v);
        return {{(XLEN-WLEN){v[WLEN-1]}}, v};
    endfunction

    // Zero-extend a word-mode value to the full register width.
    function automatic logic [XLEN-1:0] zext_word(input logic [WLEN-1:0] v);
        return {{(XLEN-WLEN){1'b0}}, v};
    endfunction

    // Two's-complement negate when requested.
    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (-v) : v;
    endfunction

endpackage

// File: rtl/ysyx_22040088_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor magnitude, keep or restore.
module ysyx_22040088_div_step
    import ysyx_22040088_defines::*;
(
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] dvs,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);

    // The extra top bit carries the shifted-out remainder bit so the trial
    // subtraction sign is exact even when the divisor magnitude is 2^63.
    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    // Shift, trial-subtract, restore on a negative result.
    always_comb begin
        shifted = {rem_in, quo_in[XLEN-1]};
        trial   = shifted - {1'b0, dvs};
        if (trial[XLEN]) begin
            rem_out = shifted[XLEN-1:0];
            quo_out = {quo_in[XLEN-2:0], 1'b0};
        end else begin
            rem_out = trial[XLEN-1:0];
            quo_out = {quo_in[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/ysyx_22040088_divider.sv
// Multi-cycle radix-2 restoring divider for the RV64M div/rem group,
// including word forms, sign correction and the RISC-V special cases.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a request, in_ready=1
// BUSY  | one quotient bit per cycle, counter counts down to 1
// FIX   | sign correction / word sign-extension, outputs registered
// DONE  | result presented with out_valid=1 until out_ready
module ysyx_22040088_divider
    import ysyx_22040088_defines::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            is_signed,
    input  logic            is_word,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    logic [1:0]      state;
    logic [CNT_W-1:0] counter;
    logic [XLEN-1:0] rem_r;
    logic [XLEN-1:0] quo_r;
    logic [XLEN-1:0] dvs_r;
    logic            neg_quo;
    logic            neg_rem;
    logic            word_r;

    logic [XLEN-1:0] a_ext;
    logic [XLEN-1:0] b_ext;
    logic [XLEN-1:0] a_w;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] min_int;
    logic [XLEN-1:0] quo_init;
    logic [CNT_W-1:0] cnt_init;
    logic            a_neg;
    logic            b_neg;
    logic            div_zero;
    logic            overflow;

    logic [XLEN-1:0] step_rem;
    logic [XLEN-1:0] step_quo;
    logic [XLEN-1:0] q_signed;
    logic [XLEN-1:0] r_signed;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    // Operand preparation and special-case detection on the live request.
    always_comb begin
        if (is_word) begin
            a_ext = is_signed ? sext_word(dividend[WLEN-1:0]) : zext_word(dividend[WLEN-1:0]);
            b_ext = is_signed ? sext_word(divisor[WLEN-1:0])  : zext_word(divisor[WLEN-1:0]);
            a_w   = sext_word(dividend[WLEN-1:0]);
            min_int  = sext_word({1'b1, {(WLEN-1){1'b0}}});
            cnt_init = CNT_W'(WLEN);
        end else begin
            a_ext = dividend;
            b_ext = divisor;
            a_w   = dividend;
            min_int  = {1'b1, {(XLEN-1){1'b0}}};
            cnt_init = CNT_W'(XLEN);
        end
        a_neg = is_signed & a_ext[XLEN-1];
        b_neg = is_signed & b_ext[XLEN-1];
        a_mag = cond_neg(a_ext, a_neg);
        b_mag = cond_neg(b_ext, b_neg);
        // Word-mode magnitudes fit in 32 bits, so park them at the top of the
        // shift register and only 32 iterations are needed.
        quo_init = is_word ? {a_mag[WLEN-1:0], {WLEN{1'b0}}} : a_mag;
        div_zero = (b_ext == '0);
        overflow = is_signed & (a_ext == min_int) & (b_ext == '1);
    end

    ysyx_22040088_div_step u_div_step (
        .rem_in  (rem_r),
        .quo_in  (quo_r),
        .dvs     (dvs_r),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    // Final sign correction and word-mode sign-extension of the raw result.
    always_comb begin
        q_signed = cond_neg(quo_r, neg_quo);
        r_signed = cond_neg(rem_r, neg_rem);
        q_fix    = word_r ? sext_word(q_signed[WLEN-1:0]) : q_signed;
        r_fix    = word_r ? sext_word(r_signed[WLEN-1:0]) : r_signed;
    end

    // Control FSM and iteration datapath; flush overrides every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            counter   <= '0;
            rem_r     <= '0;
            quo_r     <= '0;
            dvs_r     <= '0;
            neg_quo   <= 1'b0;
            neg_rem   <= 1'b0;
            word_r    <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (flush) begin
            state   <= ST_IDLE;
            counter <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (div_zero || overflow) begin
                            state     <= ST_DONE;
                            quotient  <= div_zero ? '1 : a_w;
                            remainder <= div_zero ? a_w : '0;
                        end else begin
                            state   <= ST_BUSY;
                            counter <= cnt_init;
                            rem_r   <= '0;
                            quo_r   <= quo_init;
                            dvs_r   <= b_mag;
                            neg_quo <= a_neg ^ b_neg;
                            neg_rem <= a_neg;
                            word_r  <= is_word;
                        end
                    end
                end
                ST_BUSY: begin
                    rem_r   <= step_rem;
                    quo_r   <= step_quo;
                    counter <= counter - CNT_W'(1);
                    if (counter == CNT_W'(1)) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    quotient  <= q_fix;
                    remainder <= r_fix;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040088_divider.sv
// Self-checking bench for ysyx_22040088_divider: an arithmetic reference
// model plus a negedge monitor comparing every valid output cycle.
module tb_ysyx_22040088_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] dividend = '0;
    logic [63:0] divisor = '0;
    logic        is_signed = 1'b0;
    logic        is_word = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] quotient;
    logic [63:0] remainder;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q = '0;
    logic [63:0] exp_r = '0;
    bit          armed = 1'b0;

    always #5 clk = ~clk;

    ysyx_22040088_divider dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .is_signed (is_signed),
        .is_word   (is_word),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // RISC-V M-extension semantics from plain integer arithmetic.
    function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                  input bit s, input bit w,
                                  output logic [63:0] q, output logic [63:0] r,
                                  output bit special);
        longint      sa;
        longint      sb;
        int          sa32;
        int          sb32;
        logic [31:0] q32;
        logic [31:0] r32;
        special = 1'b0;
        q = '0;
        r = '0;
        q32 = '0;
        r32 = '0;
        sa = a;
        sb = b;
        sa32 = a[31:0];
        sb32 = b[31:0];
        if (w) begin
            if (b[31:0] == 32'd0) begin
                special = 1'b1; q32 = 32'hFFFF_FFFF; r32 = a[31:0];
            end else if (s && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin
                special = 1'b1; q32 = a[31:0]; r32 = 32'd0;
            end else if (s) begin
                q32 = sa32 / sb32; r32 = sa32 % sb32;
            end else begin
                q32 = a[31:0] / b[31:0]; r32 = a[31:0] % b[31:0];
            end
            q = {{32{q32[31]}}, q32};
            r = {{32{r32[31]}}, r32};
        end else begin
            if (b == 64'd0) begin
                special = 1'b1; q = '1; r = a;
            end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
                special = 1'b1; q = a; r = '0;
            end else if (s) begin
                q = sa / sb; r = sa % sb;
            end else begin
                q = a / b; r = a % b;
            end
        end
    endfunction

    // Every cycle a result is presented it must match the model and block new requests.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (!armed) begin
                chk("unexpected_valid", {63'd0, out_valid}, 64'd0);
            end else begin
                chk("quotient", quotient, exp_q);
                chk("remainder", remainder, exp_r);
                chk("in_ready_in_done", {63'd0, in_ready}, 64'd0);
            end
        end
    end

    task automatic do_op(input logic [63:0] a, input logic [63:0] b,
                         input bit s, input bit w, input int hold);
        logic [63:0] q;
        logic [63:0] r;
        bit          sp;
        int          n;
        int          cnt;
        bit          seen;
        model(a, b, s, w, q, r, sp);
        exp_q = q;
        exp_r = r;
        armed = 1'b1;
        chk("in_ready_idle", {63'd0, in_ready}, 64'd1);
        dividend = a; divisor = b; is_signed = s; is_word = w; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        dividend  = {$urandom, $urandom};
        divisor   = {$urandom, $urandom};
        is_signed = $urandom_range(0, 1);
        is_word   = $urandom_range(0, 1);
        // Special cases land in DONE on the accept edge itself.
        n = sp ? 0 : (w ? 33 : 65);
        cnt = 0;
        seen = out_valid;
        while (!seen && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
            seen = out_valid;
        end
        chk("latency", 64'(cnt), 64'(n));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
        end
        chk("valid_held", {63'd0, out_valid}, 64'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        armed = 1'b0;
        chk("valid_after_xfer", {63'd0, out_valid}, 64'd0);
        chk("ready_after_xfer", {63'd0, in_ready}, 64'd1);
    endtask

    task automatic pin(input string name, input logic [63:0] a, input logic [63:0] b,
                       input bit s, input bit w, input logic [63:0] eq, input logic [63:0] er);
        logic [63:0] q;
        logic [63:0] r;
        bit          sp;
        model(a, b, s, w, q, r, sp);
        chk({name, "_model_q"}, q, eq);
        chk({name, "_model_r"}, r, er);
        do_op(a, b, s, w, 0);
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] b;
        bit          s;
        bit          w;
        int          sel;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_quotient", quotient, 64'd0);
        chk("rst_remainder", remainder, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        pin("s64_100_7", 64'd100, 64'd7, 1, 0, 64'd14, 64'd2);
        pin("s64_m7_2", -64'sd7, 64'd2, 1, 0, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF);
        pin("u64_max_2", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0, 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        pin("s64_div0", 64'd123, 64'd0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd123);
        pin("remw_div0", 64'd5, 64'd0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5);
        pin("divw_ovf", 64'h8000_0000, 64'hFFFF_FFFF, 1, 1, 64'hFFFF_FFFF_8000_0000, 64'd0);
        pin("divuw_hi", 64'h1_8000_0000, 64'd1, 0, 1, 64'hFFFF_FFFF_8000_0000, 64'd0);
        pin("s64_ovf", 64'h8000_0000_0000_0000, '1, 1, 0, 64'h8000_0000_0000_0000, 64'd0);

        // Backpressure: result and out_valid must stay put for 5 stalled cycles.
        do_op(64'd1000, 64'd7, 0, 0, 5);
        do_op(-64'sd1000, 64'd7, 1, 1, 5);

        // Flush in the 10th BUSY cycle abandons the operation.
        dividend = 64'd1000; divisor = 64'd3; is_signed = 1; is_word = 0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("busy_in_ready", {63'd0, in_ready}, 64'd0);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
        chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
        repeat (80) @(posedge clk);
        #1 chk("flush_no_result", {63'd0, out_valid}, 64'd0);

        // Flush with a request in IDLE: nothing is accepted.
        dividend = 64'd10; divisor = 64'd2; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_idle_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (70) @(posedge clk);
        #1 chk("flush_idle_no_result", {63'd0, out_valid}, 64'd0);

        // Flush in DONE drops the unconsumed result.
        exp_q = '1; exp_r = 64'd123; armed = 1'b1;
        dividend = 64'd123; divisor = 64'd0; is_signed = 1; is_word = 0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("done_valid", {63'd0, out_valid}, 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        armed = 1'b0;
        chk("flush_done_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_done_ready", {63'd0, in_ready}, 64'd1);

        // Reset pulse mid-BUSY returns everything to reset values at once.
        dividend = 64'd1000; divisor = 64'd3; is_signed = 0; is_word = 0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_quotient", quotient, 64'd0);
        chk("midrst_remainder", remainder, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("postrst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("postrst_out_valid", {63'd0, out_valid}, 64'd0);

        // Randomized operations, biased toward the corner cases.
        for (int k = 0; k < 150; k++) begin
            s = $urandom_range(0, 1);
            w = $urandom_range(0, 1);
            a = {$urandom, $urandom};
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                b = w ? {$urandom, 32'd0} : 64'd0;
            end else if (sel == 1) begin
                s = 1'b1;
                a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
                b = w ? {$urandom, 32'hFFFF_FFFF} : '1;
            end else if (sel <= 4) begin
                b = 64'($urandom_range(1, 100));
                if ($urandom_range(0, 1) == 1) b = -b;
            end else begin
                b = {$urandom, $urandom};
                if ($urandom_range(0, 1) == 1) b = b >> $urandom_range(0, 62);
            end
            do_op(a, b, s, w, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
